// File: rtl/brew_sequencer.sv
// Brew sequencer: walks grinder, pump, steamer and foamer through timed phases
// for one accepted drink request, then pulses done and counts the drink.
module brew_sequencer #(
  parameter int GRIND_CYC = 8,
  parameter int BREW_CYC  = 16,
  parameter int MILK_CYC  = 12,
  parameter int FOAM_CYC  = 6,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_drink,
  output logic       req_ready,
  input  logic       abort,
  output logic       grinder_on,
  output logic       pump_on,
  output logic       steam_on,
  output logic       foam_on,
  output logic       busy,
  output logic       done,
  output logic [1:0] drink_served,
  output logic [7:0] served_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRIND = 3'd1,
    ST_BREW  = 3'd2,
    ST_MILK  = 3'd3,
    ST_FOAM  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] DRINK_NONE     = 2'd0;
  localparam logic [1:0] DRINK_ESPRESSO = 2'd1;
  localparam logic [1:0] DRINK_LATTE    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GRIND_LOAD = CNT_W'(GRIND_CYC - 1);
  localparam logic [CNT_W-1:0] BREW_LOAD  = CNT_W'(BREW_CYC - 1);
  localparam logic [CNT_W-1:0] MILK_LOAD  = CNT_W'(MILK_CYC - 1);
  localparam logic [CNT_W-1:0] FOAM_LOAD  = CNT_W'(FOAM_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       drink_q, drink_d;
  logic [7:0]       served_q, served_d;
  logic             phase_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      drink_q  <= DRINK_NONE;
      served_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drink_q  <= drink_d;
      served_q <= served_d;
    end
  end

  assign phase_end = (cnt_q == CNT_ZERO);

  // Abort is tested before counter expiry in every active phase so it always wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drink_d  = drink_q;
    served_d = served_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (req_valid && (req_drink != DRINK_NONE) && !abort) begin
          state_d = ST_GRIND;
          cnt_d   = GRIND_LOAD;
          drink_d = req_drink;
        end
      end
      ST_GRIND: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          drink_d = DRINK_NONE;
        end else if (phase_end) begin
          state_d = ST_BREW;
          cnt_d   = BREW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_BREW: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          drink_d = DRINK_NONE;
        end else if (phase_end) begin
          if (drink_q == DRINK_ESPRESSO) begin
            state_d = ST_DONE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_MILK;
            cnt_d   = MILK_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_MILK: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          drink_d = DRINK_NONE;
        end else if (phase_end) begin
          if (drink_q == DRINK_LATTE) begin
            state_d = ST_DONE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_FOAM;
            cnt_d   = FOAM_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_FOAM: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          drink_d = DRINK_NONE;
        end else if (phase_end) begin
          state_d = ST_DONE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        cnt_d    = CNT_ZERO;
        drink_d  = DRINK_NONE;
        served_d = served_q + 8'd1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        drink_d = DRINK_NONE;
      end
    endcase
  end

  assign state        = state_q;
  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign grinder_on   = (state_q == ST_GRIND);
  assign pump_on      = (state_q == ST_BREW);
  assign steam_on     = (state_q == ST_MILK);
  assign foam_on      = (state_q == ST_FOAM);
  assign done         = (state_q == ST_DONE);
  assign drink_served = (state_q == ST_DONE) ? drink_q : DRINK_NONE;
  assign served_cnt   = served_q;

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
Sequences the shared brewing datapath (grinder, pump, milk steamer, foamer) once a drink has been paid for and selected. It accepts one drink request at a time from the vending FSM (1 = espresso, 2 = latte, 3 = cappuccino). It then drives each actuator for a parameterised number of cycles and signals completion. The block sits between the payment/selection FSM and the actuator drivers.

Parameters:
GRIND_CYC, 8, cycles grinder_on is held; must be >= 1
BREW_CYC, 16, cycles pump_on is held; must be >= 1
MILK_CYC, 12, cycles steam_on is held; must be >= 1
FOAM_CYC, 6, cycles foam_on is held; must be >= 1
CNT_W, 8, width of the phase down-counter; every *_CYC must be <= 2^CNT_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  drink request valid
req_drink  input  2  drink code: 1 espresso, 2 latte, 3 cappuccino, 0 invalid
req_ready  output  1  high only in IDLE
abort  input  1  synchronous cancel of the drink in progress
grinder_on  output  1  grinder enable
pump_on  output  1  water pump enable
steam_on  output  1  milk steamer enable
foam_on  output  1  foamer enable
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a drink completes
drink_served  output  2  latched drink code; valid while done is high, 0 otherwise
served_cnt  output  8  count of completed drinks
state  output  3  current state encoding, for debug

Behaviour:
- Reset and clock:
  - One clock, clk. rst_n is asynchronous and active-low.
  - While rst_n is low: state = IDLE, counter = 0, latched drink = 0, served_cnt = 0.
  - During reset, all actuator outputs, busy, done and drink_served are 0, and req_ready = 1.
- State encoding: IDLE=0, GRIND=1, BREW=2, MILK=3, FOAM=4, DONE=5. Codes 6 and 7 are unused and return to IDLE on the next edge.
- Output decoding: all outputs are Moore outputs decoded from the state register. There are no combinational paths from any input to any output.
  - grinder_on is high only in GRIND.
  - pump_on is high only in BREW.
  - steam_on is high only in MILK.
  - foam_on is high only in FOAM.
  - done is high only in DONE.
- Accept rule:
  - A request is accepted on an edge where state = IDLE, req_valid = 1, req_drink != 0 and abort = 0.
  - On acceptance, the block latches req_drink, loads the counter with GRIND_CYC-1 and moves to GRIND.
  - req_drink = 0 is ignored and the block stays in IDLE.
  - req_valid while busy is ignored; nothing is queued.
- Phase timing:
  - On entering a phase, the counter is loaded with *_CYC-1 and decrements each cycle.
  - The block leaves the phase on the edge where the counter = 0, so each phase lasts exactly *_CYC cycles.
- Transitions:
  - GRIND -> BREW for every drink.
  - BREW -> DONE for espresso; BREW -> MILK for latte and cappuccino.
  - MILK -> DONE for latte; MILK -> FOAM for cappuccino.
  - FOAM -> DONE.
  - DONE -> IDLE, unconditionally, after one cycle.
- DONE cycle: drink_served = latched code, and served_cnt increments on the DONE -> IDLE edge. served_cnt wraps from 255 to 0.
- Abort:
  - abort = 1 in GRIND, BREW, MILK or FOAM sends the block to IDLE on the next edge.
  - An aborted drink produces no done pulse and no served_cnt increment. The latched drink is cleared to 0.
  - Abort takes precedence over counter expiry.
  - abort in DONE is ignored; the drink still counts.
  - abort in IDLE blocks acceptance in that same cycle.
- Back-to-back requests: the earliest next acceptance is the edge at the end of the first IDLE cycle after DONE.
- Reset mid-drink: all actuators drop immediately (asynchronously), and nothing is counted.

Test Plan:
- Reset, then espresso (req_valid=1, req_drink=1) accepted at edge E0 -> grinder_on in cycles 1-8, pump_on in cycles 9-24, done=1 with drink_served=1 in cycle 25, IDLE in cycle 26, served_cnt=1.
- Cappuccino (req_drink=3) -> GRIND 1-8, BREW 9-24, MILK 25-36, FOAM 37-42, DONE 43. Exactly one actuator is high in every cycle 1-42.
- Latte accepted, then abort=1 in cycle 30 (MILK) -> IDLE in cycle 31, all actuators 0, no done pulse, served_cnt unchanged. A new request in cycle 31 is accepted.
- req_drink=0 with req_valid=1 in IDLE -> stays in IDLE, req_ready=1. A second request while in BREW is ignored, so exactly one done pulse is seen.
- 256 back-to-back espressos -> served_cnt wraps from 255 to 0. Each acceptance occurs no earlier than one IDLE cycle after the previous done.
- rst_n driven low in cycle 12 (BREW) -> pump_on falls with no clock edge. After release: state=IDLE, served_cnt=0, req_ready=1.
